// File: rtl/event_ctrl_pkg.sv
// Shared types and constants for the event window controller.
// Holds the FSM state encoding, default widths and fine-index width.
package event_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DEAD = 2'd3
    } state_e;

    localparam int DEF_NUM_CHANNELS = 16;
    localparam int DEF_TS_WIDTH     = 32;
    localparam int DEF_LEN_WIDTH    = 8;
    localparam int FINE_W           = 4;
    localparam int ENC_W            = 16;

endpackage

// File: rtl/lsb_prio_enc16.sv
// Lowest-set-bit priority encoder with any / more-than-one detect.
// Ports: mask (in, 16), idx (out, 4), any (out), multi (out).
module lsb_prio_enc16
    import event_ctrl_pkg::*;
(
    input  logic [ENC_W-1:0]  mask,
    output logic [FINE_W-1:0] idx,
    output logic              any,
    output logic              multi
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < ENC_W; i++) begin
            if (mask[i] && !found) begin
                idx   = i[FINE_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign any = |mask;

    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign multi = |(mask & (mask - ENC_W'(1)));

endmodule

// File: rtl/event_window_ctrl.sv
// Trigger / acquisition-window / record-out / dead-time controller.
// Ports: clk, rst_n, enable, valid_in, event_mask1/2 (in);
//        win_len, dead_len (in); capture_en, busy (out);
//        evt_valid/evt_ready handshake, evt_ts, evt_pileup, evt_hi;
//        evt_cnt (accepted records), drop_cnt (ignored triggers).
module event_window_ctrl
    import event_ctrl_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int TS_WIDTH     = DEF_TS_WIDTH,
    parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       valid_in,
    input  logic [NUM_CHANNELS-1:0]    event_mask1,
    input  logic [NUM_CHANNELS-1:0]    event_mask2,
    input  logic [LEN_WIDTH-1:0]       win_len,
    input  logic [LEN_WIDTH-1:0]       dead_len,
    output logic                       capture_en,
    output logic                       busy,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [TS_WIDTH+FINE_W-1:0] evt_ts,
    output logic                       evt_pileup,
    output logic                       evt_hi,
    output logic [31:0]                evt_cnt,
    output logic [15:0]                drop_cnt
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_e                     state_q, state_d;
    logic [TS_WIDTH-1:0]        coarse_q, coarse_d;
    logic [LEN_WIDTH-1:0]       win_cnt_q, win_cnt_d;
    logic [LEN_WIDTH-1:0]       dead_cnt_q, dead_cnt_d;
    logic [TS_WIDTH+FINE_W-1:0] ts_q, ts_d;
    logic                       pile_q, pile_d;
    logic                       hi_q, hi_d;
    logic                       valid_q, valid_d;
    logic                       cap_q, cap_d;
    logic                       busy_q, busy_d;
    logic [31:0]                evt_cnt_q, evt_cnt_d;
    logic [15:0]                drop_q, drop_d;

    logic [ENC_W-1:0]  mask16;
    logic [FINE_W-1:0] fine_idx;
    logic              enc_any;
    logic              enc_multi;
    logic              hit1;
    logic              hit2;

    // Fine index covers the first 16 samples of the cycle.
    generate
        if (NUM_CHANNELS >= ENC_W) begin : g_trunc
            assign mask16 = event_mask1[ENC_W-1:0];
        end else begin : g_pad
            assign mask16 = {{(ENC_W-NUM_CHANNELS){1'b0}}, event_mask1};
        end
    endgenerate

    lsb_prio_enc16 u_enc (
        .mask  (mask16),
        .idx   (fine_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    assign hit1 = valid_in && (|event_mask1);
    assign hit2 = valid_in && (|event_mask2);

    always_comb begin
        state_d    = state_q;
        coarse_d   = coarse_q + TS_WIDTH'(1);
        win_cnt_d  = win_cnt_q;
        dead_cnt_d = dead_cnt_q;
        ts_d       = ts_q;
        pile_d     = pile_q;
        hi_d       = hi_q;
        evt_cnt_d  = evt_cnt_q;
        drop_d     = drop_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable && hit1) begin
                    state_d   = ST_ACQ;
                    ts_d      = {coarse_q, fine_idx};
                    pile_d    = enc_multi;
                    hi_d      = hit2;
                    win_cnt_d = (win_len == '0) ? LEN_ONE : win_len;
                end
            end
            ST_ACQ: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    if (hit1) pile_d = 1'b1;
                    if (hit2) hi_d = 1'b1;
                    win_cnt_d = win_cnt_q - LEN_ONE;
                    if (win_cnt_q <= LEN_ONE) state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (hit1 && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                if (evt_ready) begin
                    evt_cnt_d = evt_cnt_q + 32'd1;
                    if (dead_len != '0) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = dead_len;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DEAD: begin
                if (hit1 && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                dead_cnt_d = dead_cnt_q - LEN_ONE;
                if (dead_cnt_q <= LEN_ONE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        cap_d   = (state_d == ST_ACQ);
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            coarse_q   <= '0;
            win_cnt_q  <= '0;
            dead_cnt_q <= '0;
            ts_q       <= '0;
            pile_q     <= 1'b0;
            hi_q       <= 1'b0;
            valid_q    <= 1'b0;
            cap_q      <= 1'b0;
            busy_q     <= 1'b0;
            evt_cnt_q  <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            coarse_q   <= coarse_d;
            win_cnt_q  <= win_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            ts_q       <= ts_d;
            pile_q     <= pile_d;
            hi_q       <= hi_d;
            valid_q    <= valid_d;
            cap_q      <= cap_d;
            busy_q     <= busy_d;
            evt_cnt_q  <= evt_cnt_d;
            drop_q     <= drop_d;
        end
    end

    assign capture_en = cap_q;
    assign busy       = busy_q;
    assign evt_valid  = valid_q;
    assign evt_ts     = ts_q;
    assign evt_pileup = pile_q;
    assign evt_hi     = hi_q;
    assign evt_cnt    = evt_cnt_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_event_window_ctrl.sv
// Scoreboard bench for event_window_ctrl (8-bit coarse timestamp).
// Directed triggers push expected records; a monitor checks them.
module tb_event_window_ctrl;

    localparam int NCH = 16;
    localparam int TSW = 8;
    localparam int LW  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic              valid_in = 1'b0;
    logic [NCH-1:0]    event_mask1 = '0;
    logic [NCH-1:0]    event_mask2 = '0;
    logic [LW-1:0]     win_len = 8'd4;
    logic [LW-1:0]     dead_len = 8'd2;
    logic              capture_en;
    logic              busy;
    logic              evt_valid;
    logic              evt_ready = 1'b1;
    logic [TSW+3:0]    evt_ts;
    logic              evt_pileup;
    logic              evt_hi;
    logic [31:0]       evt_cnt;
    logic [15:0]       drop_cnt;

    typedef struct {
        logic [TSW+3:0] ts;
        logic           pile;
        logic           hi;
        int             rise;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    event_window_ctrl #(
        .NUM_CHANNELS (NCH),
        .TS_WIDTH     (TSW),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .valid_in    (valid_in),
        .event_mask1 (event_mask1),
        .event_mask2 (event_mask2),
        .win_len     (win_len),
        .dead_len    (dead_len),
        .capture_en  (capture_en),
        .busy        (busy),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ts      (evt_ts),
        .evt_pileup  (evt_pileup),
        .evt_hi      (evt_hi),
        .evt_cnt     (evt_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; equals the coarse value being
    // sampled at the next rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_at(input int t);
        step_to(t);
        @(negedge clk);
    endtask

    task automatic pulse(input logic [NCH-1:0] m1, input logic [NCH-1:0] m2);
        valid_in    = 1'b1;
        event_mask1 = m1;
        event_mask2 = m2;
        @(posedge clk);
        #1;
        valid_in    = 1'b0;
        event_mask1 = '0;
        event_mask2 = '0;
    endtask

    task automatic expect_rec(input int t, input logic [3:0] fine,
                              input logic pile, input logic hi, input int w);
        rec_t r;
        logic [TSW-1:0] c;
        c = TSW'(t);
        r.ts   = {c, fine};
        r.pile = pile;
        r.hi   = hi;
        r.rise = t + 1 + ((w == 0) ? 1 : w);
        q.push_back(r);
    endtask

    // Monitor: checks every presented record against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (evt_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_record", 64'(evt_valid), 64'd0);
                end else begin
                    if (!prev_valid) chk("latency", 64'(cyc), 64'(q[0].rise));
                    chk("evt_ts", 64'(evt_ts), 64'(q[0].ts));
                    chk("evt_pileup", 64'(evt_pileup), 64'(q[0].pile));
                    chk("evt_hi", 64'(evt_hi), 64'(q[0].hi));
                    if (evt_ready) void'(q.pop_front());
                end
            end
            prev_valid = evt_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #3;
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_capture", 64'(capture_en), 64'd0);
        chk("rst_evt_cnt", 64'(evt_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Single trigger.
        step_to(100);
        expect_rec(100, 4'd5, 1'b0, 1'b0, 4);
        pulse(16'h0020, 16'h0000);
        check_at(102);
        chk("capture_in_acq", 64'(capture_en), 64'd1);
        check_at(110);
        chk("cnt_after_single", 64'(evt_cnt), 64'd1);
        chk("busy_after_single", 64'(busy), 64'd0);

        // Pile-up from a later crossing, hi from trigger-cycle mask2.
        step_to(120);
        expect_rec(120, 4'd5, 1'b1, 1'b1, 4);
        pulse(16'h0020, 16'h0040);
        step_to(122);
        pulse(16'h0001, 16'h0000);
        step_to(140);
        expect_rec(140, 4'd0, 1'b1, 1'b0, 4);
        pulse(16'h0101, 16'h0000);
        check_at(150);
        chk("cnt_after_pile", 64'(evt_cnt), 64'd3);
        chk("drop_none_yet", 64'(drop_cnt), 64'd0);

        // Masks ignored without valid_in.
        step_to(160);
        event_mask1 = 16'hFFFF;
        event_mask2 = 16'hFFFF;
        @(posedge clk);
        #1;
        event_mask1 = '0;
        event_mask2 = '0;
        check_at(161);
        chk("no_trig_invalid", 64'(busy), 64'd0);

        // Backpressure with drops in OUT and one in DEAD.
        step_to(180);
        evt_ready = 1'b0;
        expect_rec(180, 4'd15, 1'b0, 1'b0, 4);
        pulse(16'h8000, 16'h0000);
        step_to(182);
        win_len = 8'd9;
        step_to(186);
        pulse(16'h0002, 16'h0000);
        step_to(188);
        pulse(16'h0004, 16'h0001);
        step_to(190);
        pulse(16'h0001, 16'h0000);
        check_at(194);
        chk("stall_valid", 64'(evt_valid), 64'd1);
        chk("stall_drop", 64'(drop_cnt), 64'd3);
        chk("stall_cnt", 64'(evt_cnt), 64'd3);
        step_to(195);
        evt_ready = 1'b1;
        step_to(196);
        pulse(16'h0001, 16'h0000);
        dead_len = 8'd0;
        step_to(198);
        win_len = 8'd0;
        expect_rec(198, 4'd2, 1'b0, 1'b0, 0);
        pulse(16'h0004, 16'h0000);
        check_at(199);
        chk("w0_capture", 64'(capture_en), 64'd1);
        chk("drop_in_dead", 64'(drop_cnt), 64'd4);
        chk("cnt_after_stall", 64'(evt_cnt), 64'd4);
        check_at(200);
        chk("w0_capture_end", 64'(capture_en), 64'd0);
        check_at(201);
        chk("d0_idle", 64'(busy), 64'd0);
        chk("cnt_d0", 64'(evt_cnt), 64'd5);

        // Coarse wrap: trigger at 8'hFF, then shortly after wrap.
        win_len = 8'd1;
        step_to(255);
        expect_rec(255, 4'd10, 1'b0, 1'b1, 1);
        pulse(16'h0400, 16'h0001);
        step_to(259);
        expect_rec(259, 4'd0, 1'b1, 1'b0, 1);
        pulse(16'h0003, 16'h0000);
        check_at(265);
        chk("cnt_after_wrap", 64'(evt_cnt), 64'd7);

        // Abort mid-window.
        win_len  = 8'd4;
        dead_len = 8'd2;
        step_to(280);
        pulse(16'h0010, 16'h0000);
        step_to(282);
        enable = 1'b0;
        check_at(283);
        chk("abort_idle", 64'(busy), 64'd0);
        chk("abort_capture", 64'(capture_en), 64'd0);
        step_to(284);
        enable = 1'b1;
        check_at(295);
        chk("abort_cnt", 64'(evt_cnt), 64'd7);
        chk("abort_drop", 64'(drop_cnt), 64'd4);

        // Reset while a record is stalled in OUT.
        step_to(300);
        evt_ready = 1'b0;
        expect_rec(300, 4'd7, 1'b0, 1'b0, 4);
        pulse(16'h0080, 16'h0000);
        step_to(306);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", 64'(evt_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_cnt", 64'(evt_cnt), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        evt_ready = 1'b1;

        step_to(20);
        expect_rec(20, 4'd9, 1'b0, 1'b0, 4);
        pulse(16'h0200, 16'h0000);
        check_at(30);
        chk("post_rst_cnt", 64'(evt_cnt), 64'd1);
        chk("post_rst_drop", 64'(drop_cnt), 64'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
